instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 21 ++
 rtl/instruction_fetch_unit_if.sv | 26 ++
 rtl/instruction_fetch_unit_pc_next_calc.sv | 32 +++
 rtl/instruction_fetch_unit.sv | 70 +++++++
 tb/tb_instruction_fetch_unit.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared encodings for the instruction fetch unit: next-PC selects, FSM states
// and the default reset PC.
package instruction_fetch_unit_pkg;

    localparam logic [1:0] PCSEL_HOLD = 2'b00;
    localparam logic [1:0] PCSEL_INC  = 2'b01;
    localparam logic [1:0] PCSEL_REL  = 2'b10;
    localparam logic [1:0] PCSEL_REG  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_VALID = 2'b10;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    // Instructions are word aligned, so the two low address bits never carry information.
    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Control-unit and instruction-memory signals of the fetch unit.
// master = fetch unit side, slave = control unit / memory side.
interface instruction_fetch_unit_if;
    logic        pc_load;
    logic [1:0]  pc_sel;
    logic [63:0] constant;
    logic [63:0] reg_target;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [63:0] pc;
    logic [63:0] pc_plus4;

    modport master (
        input  pc_load, pc_sel, constant, reg_target, mem_ack, mem_rdata,
        output mem_req, mem_addr, instruction, instr_valid, pc, pc_plus4
    );

    modport slave (
        output pc_load, pc_sel, constant, reg_target, mem_ack, mem_rdata,
        input  mem_req, mem_addr, instruction, instr_valid, pc, pc_plus4
    );
endinterface

// File: rtl/instruction_fetch_unit_pc_next_calc.sv
// Combinational next-PC selection: hold, sequential, PC-relative word offset
// or absolute register target, always word aligned and wrapping modulo 2^64.
module pc_next_calc
    import instruction_fetch_unit_pkg::*;
(
    input  logic [63:0] pc,
    input  logic [1:0]  pc_sel,
    input  logic [63:0] constant,
    input  logic [63:0] reg_target,
    output logic [63:0] pc_next,
    output logic [63:0] pc_plus4
);

    logic [63:0] rel_target;

    assign pc_plus4   = pc + 64'd4;
    // Word offset: the shift drops constant[63:62], matching {constant[61:0],2'b00}.
    assign rel_target = pc + (constant << 2);

    always_comb begin
        pc_next = pc;
        case (pc_sel)
            PCSEL_HOLD: pc_next = pc;
            PCSEL_INC:  pc_next = pc_plus4;
            PCSEL_REL:  pc_next = rel_target;
            PCSEL_REG:  pc_next = reg_target;
            default:    pc_next = pc;
        endcase
        pc_next = word_align(pc_next);
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one memory read per fetch and
// registers the returned instruction for the control unit.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | just out of reset, no request outstanding
// ST_FETCH | mem_req high at pc, waiting for mem_ack
// ST_VALID | instruction holds the word at pc, waiting for pc_load
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic                     clock,
    input  logic                     reset,
    instruction_fetch_unit_if.master bus
);

    localparam logic [63:0] RESET_PC_ALIGNED = word_align(RESET_PC);

    logic [1:0]  state;
    logic [63:0] pc_q;
    logic [63:0] pc_next;
    logic [63:0] pc_plus4;
    logic [31:0] instr_q;

    pc_next_calc u_pc_next_calc (
        .pc         (pc_q),
        .pc_sel     (bus.pc_sel),
        .constant   (bus.constant),
        .reg_target (bus.reg_target),
        .pc_next    (pc_next),
        .pc_plus4   (pc_plus4)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            pc_q    <= RESET_PC_ALIGNED;
            instr_q <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (bus.mem_ack) begin
                        instr_q <= bus.mem_rdata;
                        state   <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    // The branch target is formed from the pc of the instruction being retired.
                    if (bus.pc_load) begin
                        pc_q  <= pc_next;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req     = (state == ST_FETCH);
    assign bus.mem_addr    = pc_q;
    assign bus.instr_valid = (state == ST_VALID);
    assign bus.instruction = instr_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a table of next-PC vectors applied
// from VALID, plus hand sequences for start-up, wait states and reset mid-fetch.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    instruction_fetch_unit_if bus_if ();

    instruction_fetch_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  sel;
        logic [63:0] cnst;
        logic [63:0] rt;
        logic [31:0] rdata;
        logic [63:0] exp_pc;
        logic [63:0] exp_plus4;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] last_instr;

        bus_if.pc_load    = 1'b0;
        bus_if.pc_sel     = PCSEL_HOLD;
        bus_if.constant   = 64'h0;
        bus_if.reg_target = 64'h0;
        bus_if.mem_ack    = 1'b0;
        bus_if.mem_rdata  = 32'h0;

        vecs[0]  = '{sel: PCSEL_REG,  cnst: 64'h0, rt: 64'h100, rdata: 32'h1111_0001, exp_pc: 64'h100, exp_plus4: 64'h104};
        vecs[1]  = '{sel: PCSEL_INC,  cnst: 64'h0, rt: 64'h0, rdata: 32'h1111_0002, exp_pc: 64'h104, exp_plus4: 64'h108};
        vecs[2]  = '{sel: PCSEL_REG,  cnst: 64'h0, rt: 64'h100, rdata: 32'h1111_0003, exp_pc: 64'h100, exp_plus4: 64'h104};
        vecs[3]  = '{sel: PCSEL_REL,  cnst: 64'hFFFF_FFFF_FFFF_FFFE, rt: 64'h0, rdata: 32'h1111_0004, exp_pc: 64'hF8, exp_plus4: 64'hFC};
        vecs[4]  = '{sel: PCSEL_REG,  cnst: 64'h0, rt: 64'h100, rdata: 32'h1111_0005, exp_pc: 64'h100, exp_plus4: 64'h104};
        vecs[5]  = '{sel: PCSEL_REL,  cnst: 64'h3, rt: 64'h0, rdata: 32'h1111_0006, exp_pc: 64'h10C, exp_plus4: 64'h110};
        vecs[6]  = '{sel: PCSEL_REG,  cnst: 64'h0, rt: 64'h2003, rdata: 32'h1111_0007, exp_pc: 64'h2000, exp_plus4: 64'h2004};
        vecs[7]  = '{sel: PCSEL_HOLD, cnst: 64'h5, rt: 64'h40, rdata: 32'h1111_0008, exp_pc: 64'h2000, exp_plus4: 64'h2004};
        vecs[8]  = '{sel: PCSEL_REG,  cnst: 64'h0, rt: 64'hFFFF_FFFF_FFFF_FFFC, rdata: 32'h1111_0009, exp_pc: 64'hFFFF_FFFF_FFFF_FFFC, exp_plus4: 64'h0};
        vecs[9]  = '{sel: PCSEL_INC,  cnst: 64'h0, rt: 64'h0, rdata: 32'h1111_000A, exp_pc: 64'h0, exp_plus4: 64'h4};
        vecs[10] = '{sel: PCSEL_REL,  cnst: 64'h4000_0000_0000_0001, rt: 64'h0, rdata: 32'h1111_000B, exp_pc: 64'h4, exp_plus4: 64'h8};

        // Reset values while reset is held low
        #2;
        check("rst_pc", bus_if.pc, 64'h0);
        check("rst_mem_addr", bus_if.mem_addr, 64'h0);
        check("rst_instruction", {32'h0, bus_if.instruction}, 64'h0);
        check("rst_instr_valid", {63'h0, bus_if.instr_valid}, 64'h0);
        check("rst_mem_req", {63'h0, bus_if.mem_req}, 64'h0);

        // Start-up with mem_ack tied high; edge 1 is the edge on which reset is released
        @(posedge clock);
        #1;
        reset            = 1'b1;
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'h8B02_0020;
        check("start_idle_req", {63'h0, bus_if.mem_req}, 64'h0);
        tick();
        check("start_fetch_req", {63'h0, bus_if.mem_req}, 64'h1);
        check("start_fetch_addr", bus_if.mem_addr, 64'h0);
        check("start_fetch_valid", {63'h0, bus_if.instr_valid}, 64'h0);
        tick();
        check("start_valid", {63'h0, bus_if.instr_valid}, 64'h1);
        check("start_instruction", {32'h0, bus_if.instruction}, 64'h8B02_0020);
        check("start_valid_req", {63'h0, bus_if.mem_req}, 64'h0);
        bus_if.mem_ack = 1'b0;

        // Next-PC table, each vector launched from VALID with a zero-wait ack
        for (int i = 0; i < 11; i++) begin
            bus_if.pc_load    = 1'b1;
            bus_if.pc_sel     = vecs[i].sel;
            bus_if.constant   = vecs[i].cnst;
            bus_if.reg_target = vecs[i].rt;
            tick();
            check($sformatf("v%0d_pc", i), bus_if.pc, vecs[i].exp_pc);
            check($sformatf("v%0d_mem_addr", i), bus_if.mem_addr, vecs[i].exp_pc);
            check($sformatf("v%0d_pc_plus4", i), bus_if.pc_plus4, vecs[i].exp_plus4);
            check($sformatf("v%0d_mem_req", i), {63'h0, bus_if.mem_req}, 64'h1);
            check($sformatf("v%0d_fetch_valid", i), {63'h0, bus_if.instr_valid}, 64'h0);
            bus_if.pc_load   = 1'b0;
            bus_if.mem_ack   = 1'b1;
            bus_if.mem_rdata = vecs[i].rdata;
            tick();
            bus_if.mem_ack = 1'b0;
            check($sformatf("v%0d_valid", i), {63'h0, bus_if.instr_valid}, 64'h1);
            check($sformatf("v%0d_instruction", i), {32'h0, bus_if.instruction}, {32'h0, vecs[i].rdata});
        end
        last_instr = vecs[10].rdata;

        // VALID without pc_load: mem_ack ignored, instruction and pc held
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d_instruction", i), {32'h0, bus_if.instruction}, {32'h0, last_instr});
            check($sformatf("hold%0d_valid", i), {63'h0, bus_if.instr_valid}, 64'h1);
            check($sformatf("hold%0d_pc", i), bus_if.pc, 64'h4);
        end
        bus_if.mem_ack = 1'b0;

        // Wait states: mem_ack low for 4 cycles, pc_load asserted throughout the wait
        bus_if.pc_load    = 1'b1;
        bus_if.pc_sel     = PCSEL_REG;
        bus_if.reg_target = 64'h300;
        tick();
        bus_if.pc_sel = PCSEL_INC;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("wait%0d_mem_req", i), {63'h0, bus_if.mem_req}, 64'h1);
            check($sformatf("wait%0d_mem_addr", i), bus_if.mem_addr, 64'h300);
            check($sformatf("wait%0d_pc", i), bus_if.pc, 64'h300);
            check($sformatf("wait%0d_valid", i), {63'h0, bus_if.instr_valid}, 64'h0);
        end
        bus_if.pc_load   = 1'b0;
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'h1234_5678;
        tick();
        bus_if.mem_ack = 1'b0;
        check("wait_done_valid", {63'h0, bus_if.instr_valid}, 64'h1);
        check("wait_done_instruction", {32'h0, bus_if.instruction}, 64'h1234_5678);
        check("wait_done_pc", bus_if.pc, 64'h300);

        // Reset asserted mid-FETCH, then a late ack one cycle after release
        bus_if.pc_load = 1'b1;
        bus_if.pc_sel  = PCSEL_INC;
        tick();
        bus_if.pc_load = 1'b0;
        check("midfetch_pc", bus_if.pc, 64'h304);
        check("midfetch_req", {63'h0, bus_if.mem_req}, 64'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_pc", bus_if.pc, 64'h0);
        check("async_rst_mem_addr", bus_if.mem_addr, 64'h0);
        check("async_rst_instruction", {32'h0, bus_if.instruction}, 64'h0);
        check("async_rst_mem_req", {63'h0, bus_if.mem_req}, 64'h0);
        check("async_rst_valid", {63'h0, bus_if.instr_valid}, 64'h0);
        tick();
        reset            = 1'b1;
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'hCAFE_F00D;
        tick();
        check("late_ack_instruction", {32'h0, bus_if.instruction}, 64'h0);
        check("late_ack_pc", bus_if.pc, 64'h0);
        check("late_ack_valid", {63'h0, bus_if.instr_valid}, 64'h0);
        check("restart_fetch_req", {63'h0, bus_if.mem_req}, 64'h1);
        tick();
        bus_if.mem_ack = 1'b0;
        check("restart_valid", {63'h0, bus_if.instr_valid}, 64'h1);
        check("restart_instruction", {32'h0, bus_if.instruction}, 64'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
